// File: rtl/dmem_issue_sequencer.sv
// Serializes a dual-issue load/store bundle onto the single data-memory port in program order.
// It stalls the core while the ops are replayed, then pulses per-lane responses for one cycle.
module dmem_issue_sequencer #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          stall,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StIss0,
        StWait0,
        StIss1,
        StWait1,
        StDone
    } stateT;

    localparam logic [1:0] LastCnt = (MEM_LAT == 0) ? 2'd0 : 2'(MEM_LAT - 1);

    stateT         state;
    logic [1:0]    waitCnt;
    logic          valid0Q, we0Q, valid1Q, we1Q;
    logic [AW-1:0] addr1Q, memAddrQ;
    logic [DW-1:0] wdata1Q, memWdataQ;
    logic [DW-1:0] rdata0Q, rdata1Q;
    logic          finish0, finish1;

    // A lane's op completes in ISS for stores (or any op with async read), else on the last WAIT cycle.
    always_comb begin
        finish0 = ((state == StIss0) && (we0Q || (MEM_LAT == 0))) ||
                  ((state == StWait0) && (waitCnt == LastCnt));
        finish1 = ((state == StIss1) && (we1Q || (MEM_LAT == 0))) ||
                  ((state == StWait1) && (waitCnt == LastCnt));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            waitCnt   <= 2'd0;
            valid0Q   <= 1'b0;
            we0Q      <= 1'b0;
            valid1Q   <= 1'b0;
            we1Q      <= 1'b0;
            addr1Q    <= '0;
            wdata1Q   <= '0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
            rdata0Q   <= '0;
            rdata1Q   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req0_valid || req1_valid) begin
                        valid0Q <= req0_valid;
                        we0Q    <= req0_we;
                        valid1Q <= req1_valid;
                        we1Q    <= req1_we;
                        addr1Q  <= req1_addr;
                        wdata1Q <= req1_wdata;
                        rdata0Q <= '0;
                        rdata1Q <= '0;
                        if (req0_valid) begin
                            state     <= StIss0;
                            memAddrQ  <= req0_addr;
                            memWdataQ <= req0_wdata;
                        end else begin
                            state     <= StIss1;
                            memAddrQ  <= req1_addr;
                            memWdataQ <= req1_wdata;
                        end
                    end
                end
                StIss0, StWait0: begin
                    if (finish0) begin
                        if (!we0Q) begin
                            rdata0Q <= mem_rdata;
                        end
                        if (valid1Q) begin
                            state     <= StIss1;
                            memAddrQ  <= addr1Q;
                            memWdataQ <= wdata1Q;
                        end else begin
                            state <= StDone;
                        end
                    end else if (state == StIss0) begin
                        state   <= StWait0;
                        waitCnt <= 2'd0;
                    end else begin
                        waitCnt <= waitCnt + 2'd1;
                    end
                end
                StIss1, StWait1: begin
                    if (finish1) begin
                        if (!we1Q) begin
                            rdata1Q <= mem_rdata;
                        end
                        state <= StDone;
                    end else if (state == StIss1) begin
                        state   <= StWait1;
                        waitCnt <= 2'd0;
                    end else begin
                        waitCnt <= waitCnt + 2'd1;
                    end
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    // Reset masks the strobes in the very cycle it is raised so an in-flight store cannot land.
    always_comb begin
        stall      = !reset && ((state == StIdle) ? (req0_valid || req1_valid) : (state != StDone));
        mem_we     = !reset && (((state == StIss0) && we0Q) || ((state == StIss1) && we1Q));
        mem_addr   = memAddrQ;
        mem_wdata  = memWdataQ;
        rsp0_valid = !reset && (state == StDone) && valid0Q;
        rsp1_valid = !reset && (state == StDone) && valid1Q;
        rsp0_rdata = rsp0_valid ? rdata0Q : '0;
        rsp1_rdata = rsp1_valid ? rdata1Q : '0;
    end

endmodule
